// File: rtl/mdio_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_slave_regs
//  Purpose  : MDIO (Clause 22) management responder. Oversamples MDC/MDIO in
//             the clk domain, decodes read/write frames addressed to PHY_ADDR
//             and serves a 32 x 16-bit register file:
//               reg 0      R/W, bit 15 self-clearing (soft_rst pulse)
//               reg 1      live status_i (read-only)
//               reg 2/3    PHY_ID1 / PHY_ID2 (read-only)
//               reg 4..31  plain R/W storage
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             mdc_i, mdio_i     - asynchronous MDC / MDIO pad input
//             mdio_o, mdio_oe   - MDIO drive value / output enable
//             status_i          - live value returned for reg 1
//             wr_valid/addr/data- one-clk pulse + payload of a committed write
//             rd_valid          - one-clk pulse when a served read completes
//             soft_rst          - one-clk pulse when reg 0 bit 15 written as 1
//  Options  : `define MDIO_PRE_SUPPRESS_EN to accept preamble-less frames once
//             a frame with a full preamble has completed.
//  Revision : 1.0  initial release
// ============================================================================
module mdio_slave_regs #(
   parameter logic [4:0]  PHY_ADDR = 5'h04,
   parameter logic [15:0] PHY_ID1  = 16'h001C,
   parameter logic [15:0] PHY_ID2  = 16'hC915,
   parameter logic [15:0] BMCR_RST = 16'h1140,
   parameter logic [5:0]  PRE_LEN  = 6'd32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic [15:0] status_i,
   output logic        wr_valid,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        rd_valid,
   output logic        soft_rst
);

   typedef enum logic [2:0] {
      S_PRE   = 3'd0,
      S_ST    = 3'd1,
      S_OP    = 3'd2,
      S_PHYAD = 3'd3,
      S_REGAD = 3'd4,
      S_TA    = 3'd5,
      S_DATA  = 3'd6
   } state_t;

   // Synchronisers (equal depth for MDC and MDIO) plus MDC edge history.
   // Reset to 1 so a high MDC at reset release never looks like a rise.
   logic mdc_s1_q, mdc_s2_q, mdc_s3_q;
   logic mdio_s1_q, mdio_s2_q;

   logic w_rise;
   logic w_bit;
   assign w_rise = mdc_s2_q & ~mdc_s3_q;
   assign w_bit  = mdio_s2_q;

   state_t      state_q,    state_d;
   logic [5:0]  pre_cnt_q,  pre_cnt_d;
   logic [4:0]  bit_cnt_q,  bit_cnt_d;
   logic [14:0] sh_q,       sh_d;
   logic [15:0] tx_q,       tx_d;
   logic        is_rd_q,    is_rd_d;
   logic        ignore_q,   ignore_d;
   logic [4:0]  regad_q,    regad_d;
   logic        mdio_o_q,   mdio_o_d;
   logic        mdio_oe_q,  mdio_oe_d;
   logic        wr_valid_q, wr_valid_d;
   logic [4:0]  wr_addr_q,  wr_addr_d;
   logic [15:0] wr_data_q,  wr_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        soft_rst_q, soft_rst_d;
   logic [14:0] reg0_q,     reg0_d;     // bit 15 is never stored
   logic [15:0] regs_q [0:31];          // only 4..31 are ever written
   logic [15:0] regs_d [0:31];

`ifdef MDIO_PRE_SUPPRESS_EN
   logic sup_en_q,   sup_en_d;          // preamble suppression armed
   logic full_pre_q, full_pre_d;        // current frame had a full preamble
`endif

   // Address assembled from the shift register and the bit sampled now;
   // valid on the last REGAD bit, where it selects the read snapshot.
   logic [4:0]  w_rd_sel;
   logic [15:0] w_rd_word;
   logic [15:0] w_wdata;
   logic        w_pre_ok;

   assign w_rd_sel = {sh_q[3:0], w_bit};
   assign w_wdata  = {sh_q, w_bit};

`ifdef MDIO_PRE_SUPPRESS_EN
   assign w_pre_ok = (pre_cnt_q == PRE_LEN) || sup_en_q;
`else
   assign w_pre_ok = (pre_cnt_q == PRE_LEN);
`endif

   always_comb begin
      w_rd_word = 16'h0000;
      case (w_rd_sel)
         5'd0:    w_rd_word = {1'b0, reg0_q};
         5'd1:    w_rd_word = status_i;
         5'd2:    w_rd_word = PHY_ID1;
         5'd3:    w_rd_word = PHY_ID2;
         default: w_rd_word = regs_q[w_rd_sel];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      tx_d       = tx_q;
      is_rd_d    = is_rd_q;
      ignore_d   = ignore_q;
      regad_d    = regad_q;
      mdio_o_d   = mdio_o_q;
      mdio_oe_d  = mdio_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_valid_d = 1'b0;
      soft_rst_d = 1'b0;
      reg0_d     = reg0_q;
      regs_d     = regs_q;
`ifdef MDIO_PRE_SUPPRESS_EN
      sup_en_d   = sup_en_q;
      full_pre_d = full_pre_q;
`endif

      if (w_rise) begin
         case (state_q)
            S_PRE: begin
               if (w_bit) begin
                  if (pre_cnt_q != PRE_LEN) pre_cnt_d = pre_cnt_q + 6'd1;
               end else if (w_pre_ok) begin
                  // This 0 is the first start bit.
                  state_d   = S_ST;
`ifdef MDIO_PRE_SUPPRESS_EN
                  full_pre_d = (pre_cnt_q == PRE_LEN);
`endif
                  pre_cnt_d = 6'd0;
               end else begin
                  pre_cnt_d = 6'd0;
               end
            end

            S_ST: begin
               bit_cnt_d = 5'd0;
               state_d   = w_bit ? S_OP : S_PRE;
               pre_cnt_d = 6'd0;
            end

            S_OP: begin
               sh_d = {sh_q[13:0], w_bit};
               if (bit_cnt_q == 5'd0) begin
                  bit_cnt_d = 5'd1;
               end else begin
                  bit_cnt_d = 5'd0;
                  case ({sh_q[0], w_bit})
                     2'b10:   begin is_rd_d = 1'b1; state_d = S_PHYAD; end
                     2'b01:   begin is_rd_d = 1'b0; state_d = S_PHYAD; end
                     default: state_d = S_PRE;
                  endcase
               end
            end

            S_PHYAD: begin
               sh_d = {sh_q[13:0], w_bit};
               if (bit_cnt_q == 5'd4) begin
                  // A foreign address keeps tracking the frame silently.
                  ignore_d  = (w_rd_sel != PHY_ADDR);
                  bit_cnt_d = 5'd0;
                  state_d   = S_REGAD;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end

            S_REGAD: begin
               sh_d = {sh_q[13:0], w_bit};
               if (bit_cnt_q == 5'd4) begin
                  regad_d   = w_rd_sel;
                  if (is_rd_q) tx_d = w_rd_word;
                  bit_cnt_d = 5'd0;
                  state_d   = S_TA;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end

            S_TA: begin
               if (bit_cnt_q == 5'd0) begin
                  // Drive the second turnaround bit low.
                  if (is_rd_q && !ignore_q) begin
                     mdio_oe_d = 1'b1;
                     mdio_o_d  = 1'b0;
                  end
                  bit_cnt_d = 5'd1;
               end else begin
                  if (is_rd_q && !ignore_q) begin
                     mdio_o_d = tx_q[15];
                     tx_d     = {tx_q[14:0], 1'b0};
                  end
                  bit_cnt_d = 5'd0;
                  state_d   = S_DATA;
               end
            end

            S_DATA: begin
               sh_d = {sh_q[13:0], w_bit};
               if (bit_cnt_q != 5'd15) begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (is_rd_q && !ignore_q) begin
                     mdio_o_d = tx_q[15];
                     tx_d     = {tx_q[14:0], 1'b0};
                  end
               end else begin
                  // Master is sampling D0 now: release bus, close frame.
                  bit_cnt_d = 5'd0;
                  pre_cnt_d = 6'd0;
                  state_d   = S_PRE;
`ifdef MDIO_PRE_SUPPRESS_EN
                  if (full_pre_q) sup_en_d = 1'b1;
`endif
                  if (is_rd_q) begin
                     mdio_oe_d = 1'b0;
                     mdio_o_d  = 1'b1;
                     if (!ignore_q) rd_valid_d = 1'b1;
                  end else if (!ignore_q) begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = regad_q;
                     wr_data_d  = w_wdata;
                     if (regad_q == 5'd0) begin
                        reg0_d     = w_wdata[14:0];
                        soft_rst_d = w_wdata[15];
                     end else if (regad_q >= 5'd4) begin
                        regs_d[regad_q] = w_wdata;
                     end
                  end
               end
            end

            default: begin
               state_d   = S_PRE;
               pre_cnt_d = 6'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mdc_s1_q   <= 1'b1;
         mdc_s2_q   <= 1'b1;
         mdc_s3_q   <= 1'b1;
         mdio_s1_q  <= 1'b1;
         mdio_s2_q  <= 1'b1;
         state_q    <= S_PRE;
         pre_cnt_q  <= 6'd0;
         bit_cnt_q  <= 5'd0;
         sh_q       <= 15'd0;
         tx_q       <= 16'd0;
         is_rd_q    <= 1'b0;
         ignore_q   <= 1'b0;
         regad_q    <= 5'd0;
         mdio_o_q   <= 1'b1;
         mdio_oe_q  <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 5'd0;
         wr_data_q  <= 16'd0;
         rd_valid_q <= 1'b0;
         soft_rst_q <= 1'b0;
         reg0_q     <= BMCR_RST[14:0];
         regs_q     <= '{default: 16'h0000};
`ifdef MDIO_PRE_SUPPRESS_EN
         sup_en_q   <= 1'b0;
         full_pre_q <= 1'b0;
`endif
      end else begin
         mdc_s1_q   <= mdc_i;
         mdc_s2_q   <= mdc_s1_q;
         mdc_s3_q   <= mdc_s2_q;
         mdio_s1_q  <= mdio_i;
         mdio_s2_q  <= mdio_s1_q;
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         tx_q       <= tx_d;
         is_rd_q    <= is_rd_d;
         ignore_q   <= ignore_d;
         regad_q    <= regad_d;
         mdio_o_q   <= mdio_o_d;
         mdio_oe_q  <= mdio_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_valid_q <= rd_valid_d;
         soft_rst_q <= soft_rst_d;
         reg0_q     <= reg0_d;
         regs_q     <= regs_d;
`ifdef MDIO_PRE_SUPPRESS_EN
         sup_en_q   <= sup_en_d;
         full_pre_q <= full_pre_d;
`endif
      end
   end

   assign mdio_o   = mdio_o_q;
   assign mdio_oe  = mdio_oe_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign rd_valid = rd_valid_q;
   assign soft_rst = soft_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdio_slave_regs
//  Purpose  : Self-checking bench for mdio_slave_regs. Acts as an MDIO master
//             (MDC = clk/16) and compares against a register-map model.
//  Options  : honours MDIO_PRE_SUPPRESS_EN for preamble-less expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdio_slave_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        mdc;
   logic        mdio_m;
   logic [15:0] status;
   logic        mdio_o, mdio_oe, wr_valid, rd_valid, soft_rst;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        mdio_bus;

   always #5 clk = ~clk;

   // Open-drain style bus: slave wins when enabled, else master (pull-up 1).
   assign mdio_bus = mdio_oe ? mdio_o : mdio_m;

   mdio_slave_regs dut (
      .clk      (clk),
      .rst      (rst),
      .mdc_i    (mdc),
      .mdio_i   (mdio_bus),
      .mdio_o   (mdio_o),
      .mdio_oe  (mdio_oe),
      .status_i (status),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .soft_rst (soft_rst)
   );

   int checks = 0;
   int errors = 0;

   // Cumulative event monitor, sampled on the inactive edge.
   int          oe_cnt = 0, rd_cnt = 0, wr_cnt = 0, sr_cnt = 0;
   logic [4:0]  cap_addr = 5'd0;
   logic [15:0] cap_data = 16'd0;
   always @(negedge clk) begin
      if (mdio_oe)  oe_cnt++;
      if (rd_valid) rd_cnt++;
      if (soft_rst) sr_cnt++;
      if (wr_valid) begin
         wr_cnt++;
         cap_addr = wr_addr;
         cap_data = wr_data;
      end
   end

   // Register-map reference model.
   logic [15:0] mreg [0:31];

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = 16'h0000;
      mreg[0] = 16'h1140;
   endtask

   function automatic logic [15:0] model_read(input logic [4:0] a);
      if (a == 5'd1) return status;
      if (a == 5'd2) return 16'h001C;
      if (a == 5'd3) return 16'hC915;
      return mreg[a];
   endfunction

   task automatic model_write(input logic [4:0] a, input logic [15:0] d);
      if (a == 5'd0)      mreg[0] = d & 16'h7FFF;
      else if (a >= 5'd4) mreg[a] = d;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One MDC period: low 7 clks, high 9 clks. Bus is sampled at the rise.
   task automatic mdc_bit(input logic b, output logic s);
      @(negedge clk);
      mdc    = 1'b0;
      mdio_m = b;
      repeat (7) @(negedge clk);
      s   = mdio_bus;
      mdc = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Full frame; ndata < 16 aborts after that many data bits (MDC left high).
   task automatic do_frame(input int pre, input logic rd, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd, input int ndata,
                           output logic [15:0] rdat, output logic ta);
      logic s;
      rdat = 16'h0000;
      ta   = 1'b1;
      for (int i = 0; i < pre; i++) mdc_bit(1'b1, s);
      mdc_bit(1'b0, s);
      mdc_bit(1'b1, s);
      mdc_bit(rd, s);
      mdc_bit(~rd, s);
      for (int i = 4; i >= 0; i--) mdc_bit(phy[i], s);
      for (int i = 4; i >= 0; i--) mdc_bit(ra[i], s);
      mdc_bit(1'b1, s);
      mdc_bit(rd ? 1'b1 : 1'b0, ta);
      for (int i = 15; i >= 16 - ndata; i--) begin
         mdc_bit(rd ? 1'b1 : wd[i], s);
         rdat[i] = s;
      end
      if (ndata == 16) begin
         @(negedge clk);
         mdc    = 1'b0;
         mdio_m = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic do_read(input string tag, input int pre, input logic [4:0] phy,
                          input logic [4:0] ra, input logic served);
      logic [15:0] rdat, exp;
      logic        ta;
      int          oe0, rd0;
      status = 16'($urandom);
      exp    = model_read(ra);
      oe0    = oe_cnt;
      rd0    = rd_cnt;
      do_frame(pre, 1'b1, phy, ra, 16'h0000, 16, rdat, ta);
      if (served) begin
         check({tag, " data"}, 32'(rdat), 32'(exp));
         check({tag, " ta"}, 32'(ta), 32'd0);
         check({tag, " oe_clks"}, 32'(oe_cnt - oe0), 32'd272);
         check({tag, " rd_valid"}, 32'(rd_cnt - rd0), 32'd1);
      end else begin
         check({tag, " data"}, 32'(rdat), 32'hFFFF);
         check({tag, " oe_clks"}, 32'(oe_cnt - oe0), 32'd0);
         check({tag, " rd_valid"}, 32'(rd_cnt - rd0), 32'd0);
      end
   endtask

   task automatic do_write(input string tag, input int pre, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd, input logic served);
      logic [15:0] rdat;
      logic        ta;
      int          wr0, sr0;
      wr0 = wr_cnt;
      sr0 = sr_cnt;
      do_frame(pre, 1'b0, phy, ra, wd, 16, rdat, ta);
      if (served) begin
         check({tag, " wr_valid"}, 32'(wr_cnt - wr0), 32'd1);
         check({tag, " wr_addr"}, 32'(cap_addr), 32'(ra));
         check({tag, " wr_data"}, 32'(cap_data), 32'(wd));
         check({tag, " soft_rst"}, 32'(sr_cnt - sr0), 32'((ra == 5'd0) && wd[15]));
         model_write(ra, wd);
      end else begin
         check({tag, " wr_valid"}, 32'(wr_cnt - wr0), 32'd0);
         check({tag, " soft_rst"}, 32'(sr_cnt - sr0), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] rdat;
      logic        ta;
      logic        short_served;
      logic [4:0]  ra;
      logic [15:0] wd;

      rst    = 1'b1;
      mdc    = 1'b0;
      mdio_m = 1'b1;
      status = 16'h0000;
      model_reset();
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset mdio_o",   32'(mdio_o),   32'd1);
      check("reset mdio_oe",  32'(mdio_oe),  32'd0);
      check("reset wr_valid", 32'(wr_valid), 32'd0);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset soft_rst", 32'(soft_rst), 32'd0);
      check("reset wr_addr",  32'(wr_addr),  32'd0);
      check("reset wr_data",  32'(wr_data),  32'd0);

      do_write("wr5",  32, 5'd4, 5'd5, 16'hA5A5, 1'b1);
      do_read ("rd5",  32, 5'd4, 5'd5, 1'b1);
      do_read ("rd2",  32, 5'd4, 5'd2, 1'b1);
      do_read ("rd3",  32, 5'd4, 5'd3, 1'b1);
      do_write("wr2",  32, 5'd4, 5'd2, 16'hFFFF, 1'b1);
      do_read ("rd2b", 32, 5'd4, 5'd2, 1'b1);
      do_write("wr0",  32, 5'd4, 5'd0, 16'h9140, 1'b1);
      do_read ("rd0",  32, 5'd4, 5'd0, 1'b1);
      do_read ("rd1_phy5", 32, 5'd5, 5'd1, 1'b0);
      do_write("wr9_phy5", 32, 5'd5, 5'd9, 16'h1234, 1'b0);
      do_read ("rd1",  32, 5'd4, 5'd1, 1'b1);
      do_read ("rd9",  32, 5'd4, 5'd9, 1'b1);

      // 31-bit preamble right after a completed frame.
`ifdef MDIO_PRE_SUPPRESS_EN
      short_served = 1'b1;
`else
      short_served = 1'b0;
`endif
      do_read("rd_pre31", 31, 5'd4, 5'd5, short_served);

      // Reset in the middle of a read's data phase.
      do_frame(32, 1'b1, 5'd4, 5'd5, 16'h0000, 5, rdat, ta);
      check("midrst oe_before", 32'(mdio_oe), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst oe_after", 32'(mdio_oe), 32'd0);
      check("midrst o_after",  32'(mdio_o),  32'd1);
      model_reset();
      @(negedge clk);
      mdc    = 1'b0;
      mdio_m = 1'b1;
      repeat (8) @(negedge clk);
      do_read("rd5_after_rst", 32, 5'd4, 5'd5, 1'b1);
      do_read("rd0_after_rst", 32, 5'd4, 5'd0, 1'b1);

      // Randomised write/read-back pairs.
      for (int i = 0; i < 8; i++) begin
         ra = 5'($urandom_range(0, 31));
         wd = 16'($urandom);
         do_write("rand_wr", 32, 5'd4, ra, wd, 1'b1);
         do_read ("rand_rd", 32, 5'd4, ra, 1'b1);
      end

      // Preamble suppression: full-preamble read then zero-preamble read.
      do_write("wr7", 32, 5'd4, 5'd7, 16'h5A3C, 1'b1);
      do_read ("rd7_full", 32, 5'd4, 5'd7, 1'b1);
      do_read ("rd7_nopre", 0, 5'd4, 5'd7, short_served);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
